// File: rtl/board_ctrl.sv
// Purpose: board housekeeping - SoC reset sequencing from PLL lock, button debounce, LED PWM.
// Latency: soc_rst releases RST_HOLD_CYCLES+3 edges after lock; buttons DEBOUNCE_CYCLES+2 edges; led 1 cycle.
// Backpressure: none; every output is a level or a one-cycle pulse with no handshake.
//
// Ports:
//   sys_clk, sys_rst         system clock (PLL output), async active-high reset
//   pll_locked               async PLL lock, synchronised internally
//   sw_rst_req               one-cycle SoC reset request (sys_clk domain)
//   soc_rst                  registered active-high reset to the SoC
//   btn_raw                  async push buttons, active-high
//   btn_level/press/release  debounced level and its one-cycle edge pulses
//   led_val, led_bright      LED pattern and global PWM brightness
//   led                      LED pins
module board_ctrl #(
   parameter int NUM_BTN         = 6,
   parameter int NUM_LED         = 8,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int RST_HOLD_CYCLES = 1024,
   parameter int PWM_BITS        = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                pll_locked,
   input  logic                sw_rst_req,
   output logic                soc_rst,
   input  logic [NUM_BTN-1:0]  btn_raw,
   output logic [NUM_BTN-1:0]  btn_level,
   output logic [NUM_BTN-1:0]  btn_press,
   output logic [NUM_BTN-1:0]  btn_release,
   input  logic [NUM_LED-1:0]  led_val,
   input  logic [PWM_BITS-1:0] led_bright,
   output logic [NUM_LED-1:0]  led
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Two-flop synchronisers for the asynchronous inputs
   // ------------------------------------------------------------------
   logic               lock_meta, lock_s;
   logic [NUM_BTN-1:0] btn_meta, btn_s;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
         btn_meta  <= '0;
         btn_s     <= '0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
         btn_meta  <= btn_raw;
         btn_s     <= btn_meta;
      end
   end

   // ------------------------------------------------------------------
   // Reset sequencer. soc_rst is written alongside the next state so it
   // changes on the same edge as the transition.
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } rst_state_t;

   rst_state_t        state;
   logic [HOLD_W-1:0] hold_cnt;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= WAIT_LOCK;
         hold_cnt <= '0;
         soc_rst  <= 1'b1;
      end else begin
         case (state)
            WAIT_LOCK: begin
               hold_cnt <= '0;
               soc_rst  <= 1'b1;
               if (lock_s) state <= HOLD;
            end
            HOLD: begin
               if (!lock_s) begin
                  state    <= WAIT_LOCK;
                  hold_cnt <= '0;
                  soc_rst  <= 1'b1;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= RUN;
                  hold_cnt <= '0;
                  soc_rst  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                  soc_rst  <= 1'b1;
               end
            end
            RUN: begin
               // Lock loss wins over a software request.
               if (!lock_s) begin
                  state    <= WAIT_LOCK;
                  hold_cnt <= '0;
                  soc_rst  <= 1'b1;
               end else if (sw_rst_req) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  soc_rst  <= 1'b1;
               end else begin
                  soc_rst  <= 1'b0;
               end
            end
            default: begin
               state    <= WAIT_LOCK;
               hold_cnt <= '0;
               soc_rst  <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Per-button debouncer. The counter only runs while the synchronised
   // input disagrees with the accepted level; any agreement restarts it.
   // Deliberately not gated by soc_rst.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl, prs, rls;

      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            cnt <= '0;
            lvl <= 1'b0;
            prs <= 1'b0;
            rls <= 1'b0;
         end else begin
            prs <= 1'b0;
            rls <= 1'b0;
            if (btn_s[i] == lvl) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               cnt <= '0;
               lvl <= btn_s[i];
               prs <= btn_s[i];
               rls <= ~btn_s[i];
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end
      end

      assign btn_level[i]   = lvl;
      assign btn_press[i]   = prs;
      assign btn_release[i] = rls;
   end

   // ------------------------------------------------------------------
   // Global PWM. All-ones brightness is forced fully on so the top code
   // is not one cycle short of 100%.
   // ------------------------------------------------------------------
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on;

   assign pwm_on = (&led_bright) | (pwm_cnt < led_bright);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pwm_cnt <= '0;
         led     <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         led     <= led_val & {NUM_LED{pwm_on}};
      end
   end

endmodule
